// File: rtl/mem_read_xbar_pkg.sv
// Shared definitions for the MEM-stage read crossbar: FSM/target enums, default
// region map, the decode-error data pattern and a wrap-free range helper.
package mem_read_xbar_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DECERR} xbar_state_t;
  typedef enum logic [1:0] {TGT_NONE, TGT_CLINT, TGT_MEM} xbar_tgt_t;

  localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
  localparam logic [31:0] CLINT_SIZE_DEF = 32'h0001_0000;
  localparam logic [31:0] MEM_BASE_DEF   = 32'h8000_0000;
  localparam logic [31:0] MEM_SIZE_DEF   = 32'h0800_0000;

  localparam logic [63:0] DECERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  // 33-bit arithmetic so base + size at the top of the address space cannot wrap.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/mem_read_xbar_if.sv
// One read channel (address + data handshakes). The requester uses the master
// modport, the responder the slave modport.
interface mem_read_xbar_if;

  logic [31:0] raddr;
  logic [2:0]  rsize;
  logic        raddr_valid;
  logic        raddr_ready;
  logic [63:0] rdata;
  logic        rdata_valid;
  logic        rdata_ready;

  modport master (
    output raddr, rsize, raddr_valid, rdata_ready,
    input  raddr_ready, rdata, rdata_valid
  );

  modport slave (
    input  raddr, rsize, raddr_valid, rdata_ready,
    output raddr_ready, rdata, rdata_valid
  );

endinterface

// File: rtl/mem_read_xbar_decoder.sv
// Pure combinational address decoder, shared by the read crossbar and the
// future write path. Unmapped addresses decode to TGT_NONE.
module mem_read_decoder
  import mem_read_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DEF,
  parameter logic [31:0] MEM_BASE   = MEM_BASE_DEF,
  parameter logic [31:0] MEM_SIZE   = MEM_SIZE_DEF
) (
  input  logic [31:0] addr,
  output xbar_tgt_t   tgt
);

  always_comb begin
    tgt = TGT_NONE;
    if (in_region(addr, CLINT_BASE, CLINT_SIZE)) begin
      tgt = TGT_CLINT;
    end else if (in_region(addr, MEM_BASE, MEM_SIZE)) begin
      tgt = TGT_MEM;
    end
  end

endmodule

// File: rtl/mem_read_xbar.sv
// 1-to-2 read crossbar (CLINT / AXI-lite bridge), one outstanding transaction.
// Build option XBAR_DECERR_EN: answer unmapped reads locally with an error beat.
module mem_read_xbar
  import mem_read_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DEF,
  parameter logic [31:0] MEM_BASE   = MEM_BASE_DEF,
  parameter logic [31:0] MEM_SIZE   = MEM_SIZE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_read_xbar_if.slave         mem,
  mem_read_xbar_if.master        clint,
  mem_read_xbar_if.master        axi,
`ifdef XBAR_DECERR_EN
  output logic                   mem_rdata_err,
`endif
  output xbar_state_t            state
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both high; a requester keeps valid and payload
  // stable until that edge, ready may depend combinationally on valid.

  xbar_state_t state_q, state_d;
  xbar_tgt_t   sel_q, sel_d;
  xbar_tgt_t   dec_tgt;
  xbar_tgt_t   route;
  logic        err;

  mem_read_decoder #(
    .CLINT_BASE (CLINT_BASE),
    .CLINT_SIZE (CLINT_SIZE),
    .MEM_BASE   (MEM_BASE),
    .MEM_SIZE   (MEM_SIZE)
  ) u_decoder (
    .addr (mem.raddr),
    .tgt  (dec_tgt)
  );

`ifdef XBAR_DECERR_EN
  assign route = dec_tgt;
`else
  // Without local error responses the AXI bridge is the default slave.
  assign route = (dec_tgt == TGT_NONE) ? TGT_MEM : dec_tgt;
`endif

  assign clint.raddr = mem.raddr;
  assign clint.rsize = mem.rsize;
  assign axi.raddr   = mem.raddr;
  assign axi.rsize   = mem.rsize;
  assign state       = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= TGT_NONE;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    sel_d             = sel_q;
    clint.raddr_valid = 1'b0;
    axi.raddr_valid   = 1'b0;
    clint.rdata_ready = 1'b0;
    axi.rdata_ready   = 1'b0;
    mem.raddr_ready   = 1'b0;
    mem.rdata         = '0;
    mem.rdata_valid   = 1'b0;
    err               = 1'b0;
    case (state_q)
      IDLE: begin
        case (route)
          TGT_CLINT: begin
            clint.raddr_valid = mem.raddr_valid;
            mem.raddr_ready   = clint.raddr_ready;
          end
          TGT_MEM: begin
            axi.raddr_valid = mem.raddr_valid;
            mem.raddr_ready = axi.raddr_ready;
          end
          default: mem.raddr_ready = mem.raddr_valid;
        endcase
        if (mem.raddr_valid && mem.raddr_ready) begin
          sel_d   = route;
          state_d = (route == TGT_NONE) ? DECERR : WAIT;
        end
      end
      WAIT: begin
        if (sel_q == TGT_CLINT) begin
          mem.rdata         = clint.rdata;
          mem.rdata_valid   = clint.rdata_valid;
          clint.rdata_ready = mem.rdata_ready;
        end else begin
          mem.rdata       = axi.rdata;
          mem.rdata_valid = axi.rdata_valid;
          axi.rdata_ready = mem.rdata_ready;
        end
        if (mem.rdata_valid && mem.rdata_ready) begin
          state_d = IDLE;
          sel_d   = TGT_NONE;
        end
      end
`ifdef XBAR_DECERR_EN
      DECERR: begin
        mem.rdata       = DECERR_DATA;
        mem.rdata_valid = 1'b1;
        err             = 1'b1;
        if (mem.rdata_ready) begin
          state_d = IDLE;
          sel_d   = TGT_NONE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        sel_d   = TGT_NONE;
      end
    endcase
  end

`ifdef XBAR_DECERR_EN
  assign mem_rdata_err = err;
`endif

endmodule

// File: tb/tb_mem_read_xbar.sv
// Self-checking bench for mem_read_xbar; the bench plays the MEM stage and both
// slaves. Also builds with XBAR_DECERR_EN defined.
module tb_mem_read_xbar;
  import mem_read_xbar_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  xbar_state_t state;
`ifdef XBAR_DECERR_EN
  logic        mem_rdata_err;
`endif

  always #5 clk = ~clk;

  mem_read_xbar_if mem_if();
  mem_read_xbar_if clint_if();
  mem_read_xbar_if axi_if();

  mem_read_xbar dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (mem_if),
    .clint         (clint_if),
    .axi           (axi_if),
`ifdef XBAR_DECERR_EN
    .mem_rdata_err (mem_rdata_err),
`endif
    .state         (state)
  );

  int          vec_count   = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Target codes used by the bench: 1 = CLINT, 2 = AXI bridge.
  function automatic logic slave_avalid(input int t);
    return (t == 1) ? clint_if.raddr_valid : axi_if.raddr_valid;
  endfunction

  function automatic logic slave_rready(input int t);
    return (t == 1) ? clint_if.rdata_ready : axi_if.rdata_ready;
  endfunction

  function automatic logic [31:0] slave_addr(input int t);
    return (t == 1) ? clint_if.raddr : axi_if.raddr;
  endfunction

  task automatic set_aready(input int t, input logic v);
    if (t == 1) clint_if.raddr_ready = v;
    else        axi_if.raddr_ready   = v;
  endtask

  task automatic set_resp(input int t, input logic v, input logic [63:0] d);
    if (t == 1) begin clint_if.rdata_valid = v; clint_if.rdata = d; end
    else        begin axi_if.rdata_valid   = v; axi_if.rdata   = d; end
  endtask

  task automatic clear_inputs;
    mem_if.raddr        = '0;
    mem_if.rsize        = '0;
    mem_if.raddr_valid  = 1'b0;
    mem_if.rdata_ready  = 1'b0;
    clint_if.raddr_ready = 1'b0;
    clint_if.rdata       = '0;
    clint_if.rdata_valid = 1'b0;
    axi_if.raddr_ready   = 1'b0;
    axi_if.rdata         = '0;
    axi_if.rdata_valid   = 1'b0;
  endtask

  // Full transaction: astall address-stall cycles, rlat cycles before the
  // response, rstall cycles of MEM-stage backpressure.
  task automatic read_txn(input logic [31:0] addr, input int t, input int astall,
                          input int rlat, input int rstall, input logic [63:0] data);
    int o;
    o = (t == 1) ? 2 : 1;
    @(negedge clk);
    mem_if.raddr       = addr;
    mem_if.rsize       = 3'd3;
    mem_if.raddr_valid = 1'b1;
    for (int i = 0; i < astall; i++) begin
      #1;
      check("stall_avalid", slave_avalid(t), 1'b1);
      check("stall_other_avalid", slave_avalid(o), 1'b0);
      check("stall_mem_ready", mem_if.raddr_ready, 1'b0);
      @(negedge clk);
    end
    set_aready(t, 1'b1);
    #1;
    check("accept_ready", mem_if.raddr_ready, 1'b1);
    check("accept_avalid", slave_avalid(t), 1'b1);
    check("accept_other_avalid", slave_avalid(o), 1'b0);
    check("fanout_addr_sel", slave_addr(t), addr);
    check("fanout_addr_other", slave_addr(o), addr);
    exp_q.push_back(data);
    @(negedge clk);
    mem_if.raddr_valid = 1'b0;
    set_aready(t, 1'b0);
    #1;
    check("enter_wait", state, WAIT);
    for (int i = 0; i < rlat; i++) begin
      // A new request and a spurious beat from the other slave must both be ignored.
      mem_if.raddr       = 32'h0200_0010;
      mem_if.raddr_valid = 1'b1;
      clint_if.raddr_ready = 1'b1;
      axi_if.raddr_ready   = 1'b1;
      set_resp(o, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
      #1;
      check("wait_rvalid", mem_if.rdata_valid, 1'b0);
      check("wait_mem_ready", mem_if.raddr_ready, 1'b0);
      check("wait_clint_avalid", clint_if.raddr_valid, 1'b0);
      check("wait_axi_avalid", axi_if.raddr_valid, 1'b0);
      @(negedge clk);
    end
    clint_if.raddr_ready = 1'b0;
    axi_if.raddr_ready   = 1'b0;
    set_resp(o, 1'b0, '0);
    set_resp(t, 1'b1, data);
    mem_if.rdata_ready = 1'b0;
    for (int i = 0; i < rstall; i++) begin
      mem_if.raddr_valid = 1'b1;
      #1;
      check("bp_rvalid", mem_if.rdata_valid, 1'b1);
      check("bp_rdata", mem_if.rdata, exp_q[0]);
      check("bp_slave_rready", slave_rready(t), 1'b0);
      check("bp_mem_ready", mem_if.raddr_ready, 1'b0);
      @(negedge clk);
    end
    mem_if.raddr_valid = 1'b0;
    mem_if.rdata_ready = 1'b1;
    #1;
    check("resp_rvalid", mem_if.rdata_valid, 1'b1);
    check("resp_rdata", mem_if.rdata, exp_q.pop_front());
    check("resp_slave_rready", slave_rready(t), 1'b1);
    check("resp_other_rready", slave_rready(o), 1'b0);
    @(negedge clk);
    set_resp(t, 1'b0, '0);
    mem_if.rdata_ready = 1'b0;
    #1;
    check("back_idle", state, IDLE);
    check("idle_rvalid", mem_if.rdata_valid, 1'b0);
  endtask

  // Address decode probe: valid is raised and dropped inside one clock low phase
  // so no handshake can take place.
  task automatic probe_decode(input logic [31:0] addr, input logic exp_clint, input logic exp_axi);
    @(negedge clk);
    mem_if.raddr       = addr;
    mem_if.raddr_valid = 1'b1;
    #1;
    check($sformatf("dec_clint_%h", addr), clint_if.raddr_valid, exp_clint);
    check($sformatf("dec_axi_%h", addr), axi_if.raddr_valid, exp_axi);
    #1;
    mem_if.raddr_valid = 1'b0;
  endtask

`ifdef XBAR_DECERR_EN
  task automatic decerr_txn(input logic [31:0] addr);
    @(negedge clk);
    mem_if.raddr       = addr;
    mem_if.raddr_valid = 1'b1;
    #1;
    check("decerr_accept", mem_if.raddr_ready, 1'b1);
    check("decerr_clint_avalid", clint_if.raddr_valid, 1'b0);
    check("decerr_axi_avalid", axi_if.raddr_valid, 1'b0);
    exp_q.push_back(64'hDEAD_BEEF_DEAD_BEEF);
    @(negedge clk);
    mem_if.raddr_valid = 1'b0;
    #1;
    check("decerr_state", state, DECERR);
    check("decerr_rvalid", mem_if.rdata_valid, 1'b1);
    check("decerr_err", mem_rdata_err, 1'b1);
    @(negedge clk);
    mem_if.rdata_ready = 1'b1;
    #1;
    check("decerr_rdata", mem_if.rdata, exp_q.pop_front());
    check("decerr_err_held", mem_rdata_err, 1'b1);
    @(negedge clk);
    mem_if.rdata_ready = 1'b0;
    #1;
    check("decerr_idle", state, IDLE);
    check("decerr_err_clear", mem_rdata_err, 1'b0);
  endtask
`endif

  initial begin
    logic unm_axi;
    clear_inputs();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", state, IDLE);
    check("rst_mem_ready", mem_if.raddr_ready, 1'b0);
    check("rst_rvalid", mem_if.rdata_valid, 1'b0);
    check("rst_rdata", mem_if.rdata, 64'h0);
    check("rst_clint_avalid", clint_if.raddr_valid, 1'b0);
    check("rst_axi_avalid", axi_if.raddr_valid, 1'b0);
    check("rst_clint_rready", clint_if.rdata_ready, 1'b0);
    check("rst_axi_rready", axi_if.rdata_ready, 1'b0);
`ifdef XBAR_DECERR_EN
    check("rst_err", mem_rdata_err, 1'b0);
    unm_axi = 1'b0;
`else
    unm_axi = 1'b1;
`endif

    // mtime read, then a stalled memory read with a late response
    read_txn(32'h0200_BFF8, 1, 0, 0, 0, 64'h0000_0012_3456_789A);
    read_txn(32'h8000_0100, 2, 3, 4, 0, 64'h1122_3344_5566_7788);

    // region edges
    probe_decode(32'h0200_0000, 1'b1, 1'b0);
    probe_decode(32'h0200_FFFF, 1'b1, 1'b0);
    probe_decode(32'h0201_0000, 1'b0, unm_axi);
    probe_decode(32'h01FF_FFFF, 1'b0, unm_axi);
    probe_decode(32'h8000_0000, 1'b0, 1'b1);
    probe_decode(32'h87FF_FFFF, 1'b0, 1'b1);
    probe_decode(32'h8800_0000, 1'b0, unm_axi);
    probe_decode(32'hFFFF_FFFF, 1'b0, unm_axi);

    // backpressure on the data channel with spurious CLINT beats
    read_txn(32'h8000_0200, 2, 0, 2, 5, 64'hCAFE_F00D_0BAD_C0DE);

`ifdef XBAR_DECERR_EN
    decerr_txn(32'h1000_0000);
`else
    read_txn(32'h1000_0000, 2, 1, 1, 0, 64'h0123_4567_89AB_CDEF);
`endif

    // reset while waiting for the response
    @(negedge clk);
    mem_if.raddr         = 32'h0200_4000;
    mem_if.raddr_valid   = 1'b1;
    clint_if.raddr_ready = 1'b1;
    @(negedge clk);
    mem_if.raddr_valid   = 1'b0;
    clint_if.raddr_ready = 1'b0;
    #1;
    check("rst_wait_state", state, WAIT);
    clint_if.rdata_valid = 1'b1;
    clint_if.rdata       = 64'h5555_AAAA_5555_AAAA;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_state", state, IDLE);
    check("rst_mid_rvalid", mem_if.rdata_valid, 1'b0);
    check("rst_mid_clint_rready", clint_if.rdata_ready, 1'b0);
    clear_inputs();
    read_txn(32'h0200_BFF8, 1, 1, 1, 1, 64'h0000_0000_0000_0042);

    // random traffic to both mapped regions
    for (int n = 0; n < 8; n++) begin
      int          t;
      logic [31:0] a;
      logic [63:0] d;
      t = $urandom_range(1, 2);
      a = (t == 1) ? (32'h0200_0000 | 32'($urandom_range(0, 16'hFFF8)))
                   : (32'h8000_0000 | 32'($urandom_range(0, 32'h07FF_FFF8)));
      d = {$urandom(), $urandom()};
      read_txn(a, t, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), d);
    end

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
